// File: rtl/sa_pkg.sv
// Shared types for the systolic-array result drain.
package sa_pkg;
  localparam int SA_WORD_W = 32;

  typedef logic [15:0] psum_t;

  typedef enum logic {IDLE, SEND} drain_state_e;
endpackage

// File: rtl/sa_col_fifo.sv
// Per-column synchronous FIFO with show-ahead read; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sa_col_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sa_result_drain.sv
// Deskews per-column array results into rows and streams them as 32-bit words.
// Optional macro SA_DRAIN_TAG_EN adds {row_cnt, col_cnt} tags to the upper half.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int PSUM_W   = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic [NUM_COLS-1:0]        col_v_i,
  input  logic [NUM_COLS*PSUM_W-1:0] col_psum_i,
  output logic                       v_o,
  output logic [SA_WORD_W-1:0]       data_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       overflow_o,
  output logic                       idle_o
);
  localparam int CW = $clog2(NUM_COLS);

  drain_state_e        state;
  drain_state_e        state_nx;
  logic [7:0]          col_cnt;
  logic [7:0]          col_cnt_nx;
  logic [NUM_COLS-1:0] full;
  logic [NUM_COLS-1:0] empty;
  logic [PSUM_W-1:0]   col_dout [NUM_COLS];
  logic [PSUM_W-1:0]   row_r    [NUM_COLS];
  logic                row_rdy;
  logic                pop_all;
  logic                xfer;
  logic                last_xfer;
  logic                drop;
  psum_t               sel_ext;

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
    sa_col_fifo #(.W(PSUM_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i (clk_i),
      .reset (reset),
      .push  (col_v_i[g]),
      .din   (col_psum_i[g*PSUM_W +: PSUM_W]),
      .pop   (pop_all),
      .dout  (col_dout[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign row_rdy   = &(~empty);
  assign xfer      = (state == SEND) && ready_i;
  assign last_xfer = xfer && (col_cnt == 8'(NUM_COLS-1));
  assign drop      = |(col_v_i & full & ~{NUM_COLS{pop_all}});

  always_comb begin
    state_nx   = state;
    col_cnt_nx = col_cnt;
    pop_all    = 1'b0;
    case (state)
      IDLE: begin
        if (row_rdy) begin
          pop_all    = 1'b1;
          col_cnt_nx = '0;
          state_nx   = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last_xfer) begin
            col_cnt_nx = col_cnt + 8'd1;
          end else if (row_rdy) begin
            // Reload straight from the FIFOs so rows stream without a bubble.
            pop_all    = 1'b1;
            col_cnt_nx = '0;
          end else begin
            col_cnt_nx = '0;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      col_cnt    <= '0;
      overflow_o <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) row_r[c] <= '0;
    end else begin
      state   <= state_nx;
      col_cnt <= col_cnt_nx;
      if (drop) overflow_o <= 1'b1;
      if (pop_all) begin
        for (int c = 0; c < NUM_COLS; c++) row_r[c] <= col_dout[c];
      end
    end
  end

`ifdef SA_DRAIN_TAG_EN
  logic [7:0] row_cnt;

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
    end else if (last_xfer) begin
      row_cnt <= row_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    sel_ext               = '0;
    sel_ext[PSUM_W-1:0]   = row_r[col_cnt[CW-1:0]];
    data_o                = '0;
    if (state == SEND) begin
`ifdef SA_DRAIN_TAG_EN
      data_o = {row_cnt, col_cnt, sel_ext};
`else
      data_o = {16'b0, sel_ext};
`endif
    end
  end

  assign v_o    = (state == SEND);
  assign last_o = (state == SEND) && (col_cnt == 8'(NUM_COLS-1));
  assign idle_o = (state == IDLE) && (&empty);
endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain; expected words follow SA_DRAIN_TAG_EN when defined.
module tb_sa_result_drain;
  localparam int NUM_COLS = 4;
  localparam int PSUM_W   = 16;
  localparam int DEPTH    = 4;

  logic        clk_i = 1'b0;
  logic        reset;
  logic [3:0]  col_v_i;
  logic [63:0] col_psum_i;
  logic        v_o;
  logic [31:0] data_o;
  logic        last_o;
  logic        ready_i;
  logic        overflow_o;
  logic        idle_o;

  int checks = 0;
  int errors = 0;
  int row_cnt_model = 0;

  typedef struct {
    logic [3:0]  v;
    logic [63:0] psum;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_idle;
  } vec_t;

  vec_t vecs[9];

  sa_result_drain #(.NUM_COLS(NUM_COLS), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .col_v_i    (col_v_i),
    .col_psum_i (col_psum_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .idle_o     (idle_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] psum_of(int id, int col);
    return 16'(id * 256 + (col + 1) * 17);
  endfunction

  function automatic logic [31:0] exp_word(int id, int col, int rc);
`ifdef SA_DRAIN_TAG_EN
    return {8'(rc), 8'(col), psum_of(id, col)};
`else
    return {16'h0000, psum_of(id, col)};
`endif
  endfunction

  function automatic logic [63:0] lane(int c, logic [15:0] p);
    logic [63:0] r;
    r = '0;
    r[c*16 +: 16] = p;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [63:0] psum, input logic rdy);
    col_v_i    = v;
    col_psum_i = psum;
    ready_i    = rdy;
    tick();
  endtask

  task automatic do_reset();
    col_v_i    = '0;
    col_psum_i = '0;
    ready_i    = 1'b0;
    reset      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    row_cnt_model = 0;
    tick();
  endtask

  // Wavefront: in wave cycle k, column c pushes row k-c of the burst.
  task automatic wave_cycle(input int first_id, input int n, input int k, input logic rdy);
    logic [3:0]  v;
    logic [63:0] p;
    v = '0;
    p = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (k - c >= 0 && k - c < n) begin
        v[c] = 1'b1;
        p[c*16 +: 16] = psum_of(first_id + k - c, c);
      end
    end
    apply_stimulus(v, p, rdy);
  endtask

  task automatic push_wave(input int first_id, input int n, input logic rdy);
    for (int k = 0; k < n + NUM_COLS - 1; k++) wave_cycle(first_id, n, k, rdy);
  endtask

  // Drains n_rows back-to-back; optionally pushes a whole row during word inject_word.
  task automatic drain(input int first_id, input int n_rows, input int inject_word, input int inject_id);
    int waited;
    logic [63:0] p;
    col_v_i = '0;
    ready_i = 1'b1;
    waited  = 0;
    while (v_o !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    for (int w = 0; w < n_rows * NUM_COLS; w++) begin
      check_output("drain_v", 32'(v_o), 32'd1);
      if (v_o !== 1'b1) return;
      check_output("drain_data", data_o, exp_word(first_id + w / NUM_COLS, w % NUM_COLS, row_cnt_model));
      check_output("drain_last", 32'(last_o), 32'((w % NUM_COLS) == NUM_COLS - 1));
      if (w == inject_word) begin
        p = '0;
        for (int c = 0; c < NUM_COLS; c++) p[c*16 +: 16] = psum_of(inject_id, c);
        col_v_i    = 4'b1111;
        col_psum_i = p;
      end else begin
        col_v_i = '0;
      end
      tick();
      if ((w % NUM_COLS) == NUM_COLS - 1) row_cnt_model = (row_cnt_model + 1) % 256;
    end
    col_v_i = '0;
  endtask

  initial begin
    reset      = 1'b0;
    col_v_i    = '0;
    col_psum_i = '0;
    ready_i    = 1'b0;
    #3;
    check_output("reset_v", 32'(v_o), 32'd0);
    check_output("reset_data", data_o, 32'd0);
    check_output("reset_last", 32'(last_o), 32'd0);
    check_output("reset_overflow", 32'(overflow_o), 32'd0);
    check_output("reset_idle", 32'(idle_o), 32'd1);
    do_reset();

    // Basic skewed row, ready held high.
    vecs[0] = '{4'b0001, lane(0, 16'h0011), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{4'b0010, lane(1, 16'h0022), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{4'b0100, lane(2, 16'h0033), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{4'b1000, lane(3, 16'h0044), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{4'b0000, 64'h0, 1'b1, 1'b1, exp_word(0, 0, 0), 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 64'h0, 1'b1, 1'b1, exp_word(0, 1, 0), 1'b0, 1'b0};
    vecs[6] = '{4'b0000, 64'h0, 1'b1, 1'b1, exp_word(0, 2, 0), 1'b0, 1'b0};
    vecs[7] = '{4'b0000, 64'h0, 1'b1, 1'b1, exp_word(0, 3, 0), 1'b1, 1'b0};
    vecs[8] = '{4'b0000, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].v, vecs[i].psum, vecs[i].rdy);
      check_output($sformatf("basic_v[%0d]", i), 32'(v_o), 32'(vecs[i].exp_v));
      check_output($sformatf("basic_data[%0d]", i), data_o, vecs[i].exp_data);
      check_output($sformatf("basic_last[%0d]", i), 32'(last_o), 32'(vecs[i].exp_last));
      check_output($sformatf("basic_idle[%0d]", i), 32'(idle_o), 32'(vecs[i].exp_idle));
    end
    row_cnt_model = 1;

    // Backpressure: three rows arrive over 12 stalled cycles.
    push_wave(10, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(4'b0000, 64'h0, 1'b0);
      check_output("stall_v", 32'(v_o), 32'd1);
      check_output("stall_data", data_o, exp_word(10, 0, row_cnt_model));
      check_output("stall_last", 32'(last_o), 32'd0);
      check_output("stall_overflow", 32'(overflow_o), 32'd0);
    end
    drain(10, 3, -1, 0);
    check_output("stall_idle_after", 32'(idle_o), 32'd1);

    // Full FIFOs, then a whole-row push coinciding with the row reload pop.
    do_reset();
    push_wave(20, 5, 1'b0);
    check_output("full_overflow_pre", 32'(overflow_o), 32'd0);
    drain(20, 6, 3, 25);
    check_output("full_overflow_post", 32'(overflow_o), 32'd0);
    check_output("full_idle_after", 32'(idle_o), 32'd1);

    // Overflow: six rows into a stalled drain.
    do_reset();
    for (int k = 0; k < 6 + NUM_COLS - 1; k++) begin
      wave_cycle(30, 6, k, 1'b0);
      if (k == 4) check_output("ovf_before_6th", 32'(overflow_o), 32'd0);
      if (k == 5) check_output("ovf_at_6th", 32'(overflow_o), 32'd1);
    end
    drain(30, 5, -1, 0);
    check_output("ovf_v_after", 32'(v_o), 32'd0);
    check_output("ovf_idle_after", 32'(idle_o), 32'd1);
    check_output("ovf_sticky", 32'(overflow_o), 32'd1);

    // Reset asserted mid-row, after the first word transferred.
    do_reset();
    push_wave(40, 1, 1'b1);
    col_v_i = '0;
    for (int i = 0; i < 8 && v_o !== 1'b1; i++) tick();
    check_output("midrst_word0", data_o, exp_word(40, 0, 0));
    tick();
    check_output("midrst_word1", data_o, exp_word(40, 1, 0));
    #2;
    reset = 1'b0;
    #1;
    check_output("midrst_v", 32'(v_o), 32'd0);
    check_output("midrst_idle", 32'(idle_o), 32'd1);
    check_output("midrst_data", data_o, 32'd0);
    check_output("midrst_last", 32'(last_o), 32'd0);
    tick();
    reset = 1'b1;
    row_cnt_model = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(i < 3 ? 4'(1 << i) : 4'b0000, i < 3 ? lane(i, psum_of(41, i)) : 64'h0, 1'b1);
      check_output("midrst_partial_v", 32'(v_o), 32'd0);
    end
    apply_stimulus(4'b1000, lane(3, psum_of(41, 3)), 1'b1);
    drain(41, 1, -1, 0);

    // Long run of rows, exercising row counter wrap in the tagged build.
    do_reset();
    for (int id = 0; id < 257; id++) begin
      apply_stimulus(4'b1111, lane(0, psum_of(id, 0)) | lane(1, psum_of(id, 1)) |
                     lane(2, psum_of(id, 2)) | lane(3, psum_of(id, 3)), 1'b1);
      drain(id, 1, -1, 0);
    end
    check_output("sweep_overflow", 32'(overflow_o), 32'd0);
    check_output("sweep_idle", 32'(idle_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
